irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_pkg.sv | 17 +
 rtl/irq_ctrl_if.sv | 30 +++
 rtl/rr_pick.sv | 27 ++
 rtl/irq_ctrl.sv | 96 +++++++++
 tb/tb_irq_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt controller.
// Fixed geometry: 8 request lines, 3-bit line ids.
package irq_pkg;

  localparam int NUM_IRQ  = 8;
  localparam int IRQ_ID_W = 3;

  typedef logic [NUM_IRQ-1:0]  irq_vec_t;
  typedef logic [IRQ_ID_W-1:0] irq_id_t;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    SERVICE
  } irq_state_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// Request/ack/eoi bundle between interrupt sources,
// the controller and the consumer.
interface irq_ctrl_if;
  import irq_pkg::*;

  irq_vec_t irq_in;
  logic     mask_we;
  irq_vec_t mask_wdata;
  logic     req_ack;
  logic     eoi;
  logic     req_valid;
  irq_id_t  req_id;
  logic     in_service;
  irq_vec_t pending;

  modport master (
    output irq_in, mask_we, mask_wdata,
    output req_ack, eoi,
    input  req_valid, req_id,
    input  in_service, pending
  );

  modport slave (
    input  irq_in, mask_we, mask_wdata,
    input  req_ack, eoi,
    output req_valid, req_id,
    output in_service, pending
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit at or after start_i,
// wrapping from the top line back to line 0.
module rr_pick
  import irq_pkg::*;
(
  input  irq_vec_t req_i,
  input  irq_id_t  start_i,
  output logic     found_o,
  output irq_id_t  win_o
);

  irq_id_t idx;

  always_comb begin
    found_o = 1'b0;
    win_o   = '0;
    idx     = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      idx = start_i + irq_id_t'(i);
      if (!found_o && req_i[idx]) begin
        found_o = 1'b1;
        win_o   = idx;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller with mask and
// round-robin arbitration, offering one request at a time.
module irq_ctrl
  import irq_pkg::*;
(
  input logic       clk,
  input logic       rst,
  irq_ctrl_if.slave bus
);

  irq_state_e state_q, state_d;
  irq_vec_t   irq_prev_q, irq_prev_d;
  irq_vec_t   pending_q, pending_d;
  irq_vec_t   mask_q, mask_d;
  irq_id_t    id_q, id_d;
  irq_id_t    last_id_q, last_id_d;
  logic       req_valid_q, req_valid_d;
  logic       in_service_q, in_service_d;
  irq_id_t    req_id_q, req_id_d;

  irq_vec_t   edge_vec;
  irq_vec_t   clr_vec;
  logic       found;
  irq_id_t    win;

  rr_pick u_pick (
    .req_i   (pending_q & ~mask_q),
    .start_i (last_id_q + 3'd1),
    .found_o (found),
    .win_o   (win)
  );

  always_comb begin
    edge_vec   = bus.irq_in & ~irq_prev_q;
    irq_prev_d = bus.irq_in;
    clr_vec    = '0;
    state_d    = state_q;
    id_d       = id_q;
    last_id_d  = last_id_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OFFER;
          id_d    = win;
        end
      end
      OFFER: begin
        if (bus.req_ack) begin
          state_d       = SERVICE;
          last_id_d     = id_q;
          clr_vec[id_q] = 1'b1;
        end
      end
      SERVICE: begin
        if (bus.eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a fresh edge beats the ack clear on the same line
    pending_d    = (pending_q & ~clr_vec) | edge_vec;
    mask_d       = bus.mask_we ? bus.mask_wdata : mask_q;
    req_valid_d  = (state_d == OFFER);
    in_service_d = (state_d == SERVICE);
    req_id_d     = (state_d == IDLE) ? '0 : id_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      irq_prev_q   <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      id_q         <= '0;
      last_id_q    <= 3'd7;
      req_valid_q  <= 1'b0;
      in_service_q <= 1'b0;
      req_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      irq_prev_q   <= irq_prev_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      id_q         <= id_d;
      last_id_q    <= last_id_d;
      req_valid_q  <= req_valid_d;
      in_service_q <= in_service_d;
      req_id_q     <= req_id_d;
    end
  end

  assign bus.req_valid  = req_valid_q;
  assign bus.in_service = in_service_q;
  assign bus.req_id     = req_id_q;
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed table, corner sequences,
// then random traffic against a behavioural model.
module tb_irq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  irq_ctrl_if bus ();

  irq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst;
    logic [7:0] irq;
    logic       mwe;
    logic [7:0] mwd;
    logic       ack;
    logic       eoi;
    logic       valid;
    logic [2:0] id;
    logic       svc;
    logic [7:0] pend;
  } vec_t;

  vec_t tbl[$];

  // behavioural model: mode 0 idle, 1 offered, 2 serviced
  int         m_mode;
  int         m_cur;
  int         m_last;
  logic [7:0] m_pend;
  logic [7:0] m_mask;
  logic [7:0] m_prev;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, got, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [7:0] irq,
                       input logic mwe, input logic [7:0] mwd,
                       input logic ack, input logic e);
    rst            = r;
    bus.irq_in     = irq;
    bus.mask_we    = mwe;
    bus.mask_wdata = mwd;
    bus.req_ack    = ack;
    bus.eoi        = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [7:0] irq,
                     input logic mwe, input logic [7:0] mwd,
                     input logic ack, input logic e,
                     input logic v, input logic [2:0] id,
                     input logic s, input logic [7:0] p);
    vec_t t;
    t.rst = r; t.irq = irq; t.mwe = mwe; t.mwd = mwd;
    t.ack = ack; t.eoi = e;
    t.valid = v; t.id = id; t.svc = s; t.pend = p;
    tbl.push_back(t);
  endtask

  task automatic outs(input string tag, input logic v,
                      input logic [2:0] id, input logic s,
                      input logic [7:0] p);
    chk({tag, ".valid"}, 32'(bus.req_valid), 32'(v));
    chk({tag, ".id"}, 32'(bus.req_id), 32'(id));
    chk({tag, ".svc"}, 32'(bus.in_service), 32'(s));
    chk({tag, ".pend"}, 32'(bus.pending), 32'(p));
  endtask

  task automatic m_step(input logic r, input logic [7:0] irq,
                        input logic mwe, input logic [7:0] mwd,
                        input logic ack, input logic e);
    logic [7:0] ev;
    logic [7:0] clr;
    int         nmode;
    bit         hit;
    int         ln;
    if (r) begin
      m_mode = 0; m_cur = 0; m_last = 7;
      m_pend = 0; m_mask = 0; m_prev = 0;
      return;
    end
    ev    = irq & ~m_prev;
    clr   = 0;
    nmode = m_mode;
    hit   = 0;
    if (m_mode == 0) begin
      for (int k = 1; k <= 8; k++) begin
        ln = (m_last + k) % 8;
        if (!hit && m_pend[ln] && !m_mask[ln]) begin
          hit = 1; m_cur = ln; nmode = 1;
        end
      end
    end else if (m_mode == 1) begin
      if (ack) begin
        nmode = 2; m_last = m_cur; clr[m_cur] = 1'b1;
      end
    end else if (e) begin
      nmode = 0;
    end
    m_mode = nmode;
    m_pend = (m_pend & ~clr) | ev;
    if (mwe) m_mask = mwd;
    m_prev = irq;
  endtask

  initial begin
    logic [7:0] ri;
    logic       rr, rw, ra, re;
    logic [7:0] rm;

    drive(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // basic offer / ack / eoi on line 3
    add(1, 8'h00, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h00);
    add(0, 8'h08, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h08);
    add(0, 8'h08, 0, 8'h00, 0, 0, 1, 3'd3, 0, 8'h08);
    add(0, 8'h08, 0, 8'h00, 0, 0, 1, 3'd3, 0, 8'h08);
    add(0, 8'h08, 0, 8'h00, 1, 0, 0, 3'd3, 1, 8'h00);
    add(0, 8'h08, 0, 8'h00, 0, 0, 0, 3'd3, 1, 8'h00);
    add(0, 8'h08, 0, 8'h00, 0, 1, 0, 3'd0, 0, 8'h00);
    add(0, 8'h00, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h00);
    // masked line pends but is not offered until unmasked
    add(0, 8'h00, 1, 8'h10, 0, 0, 0, 3'd0, 0, 8'h00);
    add(0, 8'h10, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h10);
    add(0, 8'h10, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h10);
    add(0, 8'h10, 1, 8'h00, 0, 0, 0, 3'd0, 0, 8'h10);
    add(0, 8'h10, 0, 8'h00, 0, 0, 1, 3'd4, 0, 8'h10);
    // stray eoi in OFFER, reset in SERVICE and OFFER
    add(0, 8'h10, 0, 8'h00, 0, 1, 1, 3'd4, 0, 8'h10);
    add(0, 8'h10, 0, 8'h00, 1, 0, 0, 3'd4, 1, 8'h00);
    add(1, 8'h10, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h00);
    add(0, 8'h10, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h10);
    add(0, 8'h10, 0, 8'h00, 0, 0, 1, 3'd4, 0, 8'h10);
    add(1, 8'h00, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h00);
    add(0, 8'h00, 0, 8'h00, 1, 0, 0, 3'd0, 0, 8'h00);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].irq, tbl[i].mwe,
            tbl[i].mwd, tbl[i].ack, tbl[i].eoi);
      tick();
      outs($sformatf("tbl%0d", i), tbl[i].valid,
           tbl[i].id, tbl[i].svc, tbl[i].pend);
    end

    // round-robin from last_id=2 with lines 7 and 0
    drive(1, 8'h00, 0, 8'h00, 0, 0); tick();
    drive(0, 8'h04, 0, 8'h00, 0, 0); tick();
    tick();
    drive(0, 8'h04, 0, 8'h00, 1, 0); tick();
    drive(0, 8'h04, 0, 8'h00, 0, 1); tick();
    drive(0, 8'h00, 0, 8'h00, 0, 0); tick();
    drive(0, 8'h81, 0, 8'h00, 0, 0); tick();
    outs("rr.pend", 0, 3'd0, 0, 8'h81);
    tick();
    outs("rr.first", 1, 3'd7, 0, 8'h81);
    drive(0, 8'h81, 0, 8'h00, 1, 0); tick();
    outs("rr.svc7", 0, 3'd7, 1, 8'h01);
    drive(0, 8'h81, 0, 8'h00, 0, 1); tick();
    drive(0, 8'h81, 0, 8'h00, 0, 0); tick();
    outs("rr.wrap", 1, 3'd0, 0, 8'h01);

    // ack collides with a new edge on the same line
    drive(1, 8'h00, 0, 8'h00, 0, 0); tick();
    drive(0, 8'h02, 0, 8'h00, 0, 0); tick();
    drive(0, 8'h00, 0, 8'h00, 0, 0); tick();
    outs("col.offer", 1, 3'd1, 0, 8'h02);
    drive(0, 8'h02, 0, 8'h00, 1, 0); tick();
    outs("col.ack", 0, 3'd1, 1, 8'h02);
    drive(0, 8'h02, 0, 8'h00, 0, 1); tick();
    outs("col.eoi", 0, 3'd0, 0, 8'h02);
    drive(0, 8'h02, 0, 8'h00, 0, 0); tick();
    outs("col.reoffer", 1, 3'd1, 0, 8'h02);

    // random traffic against the model
    drive(1, 8'h00, 0, 8'h00, 0, 0); tick();
    m_step(1, 8'h00, 0, 8'h00, 0, 0);
    ri = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      ri = ri ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      rr = ($urandom_range(0, 199) == 0);
      rw = ($urandom_range(0, 9) == 0);
      rm = 8'($urandom) & 8'($urandom);
      ra = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 3) == 0);
      drive(rr, ri, rw, rm, ra, re);
      m_step(rr, ri, rw, rm, ra, re);
      tick();
      outs($sformatf("rnd%0d", c), m_mode == 1,
           (m_mode == 0) ? 3'd0 : 3'(m_cur),
           m_mode == 2, m_pend);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
